// File: rtl/dmx_pkg.sv
// Shared AXI4-Stream definitions for the tx distributor (dmx) and its rx
// counterpart (mxr): bus widths, destination-port field offset, the
// distributor FSM state type and the route decode helper.
package dmx_pkg;

    localparam int AXIS_DATA_W  = 64;
    localparam int AXIS_STRB_W  = 8;
    localparam int AXIS_USER_W  = 128;
    localparam int DST_PORT_OFS = 24;

    // One buffered beat: tdata, tstrb, tuser, tlast packed MSB to LSB.
    localparam int BEAT_W = AXIS_DATA_W + AXIS_STRB_W + AXIS_USER_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FWD_A    = 3'd1,
        ST_FWD_D    = 3'd2,
        ST_FWD_BOTH = 3'd3,
        ST_DROP     = 3'd4
    } dmx_state_t;

    // Map the two one-hot destination bits of an SOP beat to a route.
    function automatic dmx_state_t route_decode(input logic dst_a, input logic dst_d);
        dmx_state_t r;
        case ({dst_a, dst_d})
            2'b10:   r = ST_FWD_A;
            2'b01:   r = ST_FWD_D;
            2'b11:   r = ST_FWD_BOTH;
            default: r = ST_DROP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmx_axis_skid.sv
// axis_skid: two-entry registered AXI4-Stream slice.
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   wr_en, wr_beat       write strobe (already qualified by wr_ready) and beat
//   wr_ready             registered not-full flag (low while two beats held)
//   rd_valid, rd_beat    registered output handshake and payload
//   rd_ready             downstream ready
// The output register is always the oldest beat; the skid register holds the
// second beat only when the output is stalled. wr_ready is a pure flop, so
// there is no combinational path from rd_ready back to the writer.
module axis_skid
    import dmx_pkg::*;
#(
    parameter int W = BEAT_W
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_beat,
    output logic         wr_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_beat,
    input  logic         rd_ready
);

    logic         out_valid_r;
    logic [W-1:0] out_beat_r;
    logic         skid_valid_r;
    logic [W-1:0] skid_beat_r;
    logic         pop_s;

    assign pop_s    = out_valid_r & rd_ready;
    assign wr_ready = ~skid_valid_r;
    assign rd_valid = out_valid_r;
    assign rd_beat  = out_beat_r;

    // Output/skid register update: shift skid forward on pop, park a new beat in skid on stall.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid_r  <= 1'b0;
            out_beat_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_beat_r  <= '0;
        end else begin
            case ({skid_valid_r, out_valid_r})
                2'b11: begin
                    if (pop_s) begin
                        out_beat_r   <= skid_beat_r;
                        skid_valid_r <= 1'b0;
                    end
                end
                2'b01: begin
                    if (pop_s && wr_en) begin
                        out_beat_r <= wr_beat;
                    end else if (pop_s) begin
                        out_valid_r <= 1'b0;
                    end else if (wr_en) begin
                        skid_beat_r  <= wr_beat;
                        skid_valid_r <= 1'b1;
                    end
                end
                2'b00: begin
                    if (wr_en) begin
                        out_beat_r  <= wr_beat;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    // Skid full with empty output cannot occur; recover to empty.
                    out_valid_r  <= 1'b0;
                    skid_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmx.sv
// dmx: transmit-side packet distributor. Steers each whole packet of the DMA
// tx stream to MAC A, MAC D, both, or a drop sink, from the one-hot
// destination bits of the SOP beat's tuser.
// Ports:
//   clk, arst_n                       pcie clock, asynchronous active-low reset
//   s_axis_*                          input stream from the DMA engine
//   m_axis_A_*, m_axis_D_*            output streams to the two MACs
//   drop_cnt                          number of dropped packets (wraps)
module dmx
    import dmx_pkg::*;
#(
    parameter int DST_A_BIT = DST_PORT_OFS,
    parameter int DST_D_BIT = DST_PORT_OFS + 6
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_STRB_W-1:0] s_axis_tstrb,
    input  logic [AXIS_USER_W-1:0] s_axis_tuser,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [AXIS_DATA_W-1:0] m_axis_A_tdata,
    output logic [AXIS_STRB_W-1:0] m_axis_A_tstrb,
    output logic [AXIS_USER_W-1:0] m_axis_A_tuser,
    output logic                   m_axis_A_tvalid,
    output logic                   m_axis_A_tlast,
    input  logic                   m_axis_A_tready,
    output logic [AXIS_DATA_W-1:0] m_axis_D_tdata,
    output logic [AXIS_STRB_W-1:0] m_axis_D_tstrb,
    output logic [AXIS_USER_W-1:0] m_axis_D_tuser,
    output logic                   m_axis_D_tvalid,
    output logic                   m_axis_D_tlast,
    input  logic                   m_axis_D_tready,
    output logic [31:0]            drop_cnt
);

    dmx_state_t        state_r;
    dmx_state_t        route_s;
    logic              to_a_s;
    logic              to_d_s;
    logic              ready_s;
    logic              accept_s;
    logic              rdy_a_s;
    logic              rdy_d_s;
    logic [BEAT_W-1:0] in_beat_s;
    logic [BEAT_W-1:0] a_beat_s;
    logic [BEAT_W-1:0] d_beat_s;
    logic [31:0]       drop_cnt_r;

    assign in_beat_s = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};

    // Effective route: decoded from the SOP beat in IDLE, otherwise held by the FSM.
    always_comb begin
        route_s = ST_IDLE;
        if (state_r == ST_IDLE) begin
            route_s = route_decode(s_axis_tuser[DST_A_BIT], s_axis_tuser[DST_D_BIT]);
        end else begin
            route_s = state_r;
        end
    end

    // Input ready and per-slice write enables for the effective route.
    always_comb begin
        ready_s = 1'b0;
        to_a_s  = 1'b0;
        to_d_s  = 1'b0;
        case (route_s)
            ST_FWD_A: begin
                ready_s = rdy_a_s;
                to_a_s  = 1'b1;
            end
            ST_FWD_D: begin
                ready_s = rdy_d_s;
                to_d_s  = 1'b1;
            end
            ST_FWD_BOTH: begin
                // Broadcast only moves when both slices have room.
                ready_s = rdy_a_s & rdy_d_s;
                to_a_s  = 1'b1;
                to_d_s  = 1'b1;
            end
            ST_DROP: begin
                ready_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Ready is forced low while reset is asserted.
    assign s_axis_tready = ready_s & arst_n;
    assign accept_s      = s_axis_tvalid & s_axis_tready;

    // Packet FSM and drop counter: route latched at SOP, released on accepted tlast.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= ST_IDLE;
            drop_cnt_r <= 32'd0;
        end else if (accept_s) begin
            if (s_axis_tlast) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= route_s;
            end
            if ((state_r == ST_IDLE) && (route_s == ST_DROP)) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end
        end
    end

    assign drop_cnt = drop_cnt_r;

    axis_skid #(.W(BEAT_W)) u_skid_a (
        .clk      (clk),
        .arst_n   (arst_n),
        .wr_en    (accept_s & to_a_s),
        .wr_beat  (in_beat_s),
        .wr_ready (rdy_a_s),
        .rd_valid (m_axis_A_tvalid),
        .rd_beat  (a_beat_s),
        .rd_ready (m_axis_A_tready)
    );

    axis_skid #(.W(BEAT_W)) u_skid_d (
        .clk      (clk),
        .arst_n   (arst_n),
        .wr_en    (accept_s & to_d_s),
        .wr_beat  (in_beat_s),
        .wr_ready (rdy_d_s),
        .rd_valid (m_axis_D_tvalid),
        .rd_beat  (d_beat_s),
        .rd_ready (m_axis_D_tready)
    );

    assign {m_axis_A_tdata, m_axis_A_tstrb, m_axis_A_tuser, m_axis_A_tlast} = a_beat_s;
    assign {m_axis_D_tdata, m_axis_D_tstrb, m_axis_D_tuser, m_axis_D_tlast} = d_beat_s;

endmodule

// File: tb/tb_dmx.sv
// Self-checking bench for dmx: a packet-level model (per-port expected beat
// queues filled on input accepts, routed by SOP destination bits) checked on
// every cycle, plus directed literal expectations per scenario.
module tb_dmx;

    logic         clk = 1'b0;
    logic         arst_n;
    logic [63:0]  s_axis_tdata;
    logic [7:0]   s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [63:0]  m_axis_A_tdata;
    logic [7:0]   m_axis_A_tstrb;
    logic [127:0] m_axis_A_tuser;
    logic         m_axis_A_tvalid;
    logic         m_axis_A_tlast;
    logic         m_axis_A_tready;
    logic [63:0]  m_axis_D_tdata;
    logic [7:0]   m_axis_D_tstrb;
    logic [127:0] m_axis_D_tuser;
    logic         m_axis_D_tvalid;
    logic         m_axis_D_tlast;
    logic         m_axis_D_tready;
    logic [31:0]  drop_cnt;

    dmx #(.DST_A_BIT(24), .DST_D_BIT(30)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tstrb    (s_axis_tstrb),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_A_tdata  (m_axis_A_tdata),
        .m_axis_A_tstrb  (m_axis_A_tstrb),
        .m_axis_A_tuser  (m_axis_A_tuser),
        .m_axis_A_tvalid (m_axis_A_tvalid),
        .m_axis_A_tlast  (m_axis_A_tlast),
        .m_axis_A_tready (m_axis_A_tready),
        .m_axis_D_tdata  (m_axis_D_tdata),
        .m_axis_D_tstrb  (m_axis_D_tstrb),
        .m_axis_D_tuser  (m_axis_D_tuser),
        .m_axis_D_tvalid (m_axis_D_tvalid),
        .m_axis_D_tlast  (m_axis_D_tlast),
        .m_axis_D_tready (m_axis_D_tready),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [200:0] beat_t;

    beat_t a_beat_s, d_beat_s, in_beat_s;
    assign a_beat_s  = {m_axis_A_tdata, m_axis_A_tstrb, m_axis_A_tuser, m_axis_A_tlast};
    assign d_beat_s  = {m_axis_D_tdata, m_axis_D_tstrb, m_axis_D_tuser, m_axis_D_tlast};
    assign in_beat_s = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state (owned by the monitor) ----------------
    beat_t qa[$];
    beat_t qd[$];
    logic  in_pkt = 1'b0, rt_a = 1'b0, rt_d = 1'b0;
    int    exp_drop = 0;
    int    acc_total = 0, cnt_a = 0, cnt_d = 0;
    int    a_valid_cycles = 0, d_valid_cycles = 0;
    int    a_rise_cyc = 0, a_last_cyc = 0, d_last_cyc = 0;
    logic  a_hold = 1'b0, d_hold = 1'b0, a_pv = 1'b0, d_pv = 1'b0;
    beat_t a_prev, d_prev;

    // Monitor/scoreboard: sample away from the active edge
    always @(negedge clk) begin
        if (!arst_n) begin
            qa.delete(); qd.delete();
            in_pkt = 1'b0; exp_drop = 0;
            a_hold = 1'b0; d_hold = 1'b0; a_pv = 1'b0; d_pv = 1'b0;
        end else begin
            check("drop_cnt", 256'(drop_cnt), 256'(exp_drop));
            // port A
            if (a_hold) begin
                check("A_hold_valid", 256'(m_axis_A_tvalid), 256'(1));
                check("A_hold_payload", 256'(a_beat_s), 256'(a_prev));
            end
            if (m_axis_A_tvalid) a_valid_cycles++;
            if (m_axis_A_tvalid && !a_pv) a_rise_cyc = cyc;
            if (m_axis_A_tvalid && m_axis_A_tready) begin
                if (qa.size() == 0) check("A_unexpected_beat", 256'(1), 256'(0));
                else begin
                    check("A_beat", 256'(a_beat_s), 256'(qa.pop_front()));
                    cnt_a++;
                    if (m_axis_A_tlast) a_last_cyc = cyc;
                end
            end
            a_hold = m_axis_A_tvalid & ~m_axis_A_tready;
            a_prev = a_beat_s;
            a_pv   = m_axis_A_tvalid;
            // port D
            if (d_hold) begin
                check("D_hold_valid", 256'(m_axis_D_tvalid), 256'(1));
                check("D_hold_payload", 256'(d_beat_s), 256'(d_prev));
            end
            if (m_axis_D_tvalid) d_valid_cycles++;
            if (m_axis_D_tvalid && m_axis_D_tready) begin
                if (qd.size() == 0) check("D_unexpected_beat", 256'(1), 256'(0));
                else begin
                    check("D_beat", 256'(d_beat_s), 256'(qd.pop_front()));
                    cnt_d++;
                    if (m_axis_D_tlast) d_last_cyc = cyc;
                end
            end
            d_hold = m_axis_D_tvalid & ~m_axis_D_tready;
            d_prev = d_beat_s;
            d_pv   = m_axis_D_tvalid;
            // input accept: route chosen at SOP, held to tlast
            if (s_axis_tvalid && s_axis_tready) begin
                acc_total++;
                if (!in_pkt) begin
                    rt_a = s_axis_tuser[24];
                    rt_d = s_axis_tuser[30];
                    if (!rt_a && !rt_d) exp_drop++;
                end
                if (rt_a) qa.push_back(in_beat_s);
                if (rt_d) qd.push_back(in_beat_s);
                in_pkt = ~s_axis_tlast;
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    logic want_a = 1'b1, want_d = 1'b1, tog_d = 1'b0, probe_en = 1'b0, probe_r;

    initial begin
        m_axis_A_tready = 1'b1;
        m_axis_D_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_A_tready = want_a;
            if (tog_d) m_axis_D_tready = ~m_axis_D_tready;
            else       m_axis_D_tready = want_d;
            if (probe_en) begin
                // Flip D ready mid-cycle: input ready must not follow it.
                #1;
                probe_r = s_axis_tready;
                m_axis_D_tready = ~m_axis_D_tready;
                #1;
                check("no_comb_ready_path", 256'(s_axis_tready), 256'(probe_r));
                m_axis_D_tready = ~m_axis_D_tready;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pkt(input int n, input logic a, input logic d, input logic [15:0] tag,
                            output int first_cyc, output int last_cyc, output int stalls);
        logic acc;
        stalls = 0; first_cyc = 0; last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            s_axis_tdata  = {tag, i[15:0], $urandom()};
            s_axis_tstrb  = 8'($urandom());
            s_axis_tuser  = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 0) begin
                s_axis_tuser[24] = a;
                s_axis_tuser[30] = d;
            end
            s_axis_tlast  = (i == n - 1);
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                acc = s_axis_tready;
                if (acc) begin
                    if (i == 0) first_cyc = cyc;
                    last_cyc = cyc;
                end else begin
                    stalls++;
                    if (stalls > 300) begin
                        check("send_timeout", 256'(0), 256'(1));
                        s_axis_tvalid = 1'b0;
                        s_axis_tlast  = 1'b0;
                        return;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (qa.size() != 0 || qd.size() != 0); k++) @(posedge clk);
        check("drain_A_empty", 256'(qa.size()), 256'(0));
        check("drain_D_empty", 256'(qd.size()), 256'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int f1, l1, s1, f2, l2, s2, a0, d0, av0, dv0, acc0;

    initial begin
        arst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        // reset state
        check("rst_A_tvalid", 256'(m_axis_A_tvalid), 256'(0));
        check("rst_D_tvalid", 256'(m_axis_D_tvalid), 256'(0));
        check("rst_s_tready", 256'(s_axis_tready), 256'(0));
        check("rst_drop_cnt", 256'(drop_cnt), 256'(0));
        check("rst_A_payload", 256'(a_beat_s), 256'(0));
        check("rst_D_payload", 256'(d_beat_s), 256'(0));
        @(negedge clk);
        arst_n = 1'b1;
        s_axis_tuser[24] = 1'b1;
        #1;
        check("post_rst_s_tready", 256'(s_axis_tready), 256'(1));
        s_axis_tuser = '0;
        @(posedge clk);
        #1;

        // Route A: 4 beats, 1-cycle latency, D never valid
        a0 = cnt_a; dv0 = d_valid_cycles;
        send_pkt(4, 1'b1, 1'b0, 16'hA001, f1, l1, s1);
        drain();
        check("A_beats", 256'(cnt_a - a0), 256'(4));
        check("A_latency_first", 256'(a_rise_cyc - f1), 256'(1));
        check("A_latency_last", 256'(a_last_cyc - l1), 256'(1));
        check("A_no_D_valid", 256'(d_valid_cycles - dv0), 256'(0));
        check("A_drop_cnt", 256'(drop_cnt), 256'(0));
        check("A_no_stall", 256'(s1), 256'(0));

        // Broadcast: D ready low, input stalls after 2 beats
        want_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a0 = cnt_a; d0 = cnt_d; acc0 = acc_total;
        fork
            send_pkt(3, 1'b1, 1'b1, 16'hB002, f1, l1, s1);
            begin
                repeat (5) @(posedge clk);
                check("bc_stall_after_2", 256'(acc_total - acc0), 256'(2));
                want_d = 1'b1;
            end
        join
        drain();
        check("bc_A_beats", 256'(cnt_a - a0), 256'(3));
        check("bc_D_beats", 256'(cnt_d - d0), 256'(3));
        check("bc_A_not_after_D", 256'(a_last_cyc <= d_last_cyc), 256'(1));

        // Drop: 5-beat and 1-beat packets, never stall, no output
        av0 = a_valid_cycles; dv0 = d_valid_cycles;
        send_pkt(5, 1'b0, 1'b0, 16'hC003, f1, l1, s1);
        send_pkt(1, 1'b0, 1'b0, 16'hC004, f2, l2, s2);
        drain();
        check("drop_no_stall", 256'(s1 + s2), 256'(0));
        check("drop_cnt_2", 256'(drop_cnt), 256'(2));
        check("drop_no_A_valid", 256'(a_valid_cycles - av0), 256'(0));
        check("drop_no_D_valid", 256'(d_valid_cycles - dv0), 256'(0));

        // Backpressure: D ready toggles each cycle during a 16-beat D packet
        d0 = cnt_d; av0 = a_valid_cycles;
        tog_d = 1'b1; probe_en = 1'b1;
        send_pkt(16, 1'b0, 1'b1, 16'hD005, f1, l1, s1);
        tog_d = 1'b0; probe_en = 1'b0;
        drain();
        check("bp_D_beats", 256'(cnt_d - d0), 256'(16));
        check("bp_no_A_valid", 256'(a_valid_cycles - av0), 256'(0));

        // Back-to-back: A then D with no input bubble
        a0 = cnt_a; d0 = cnt_d;
        send_pkt(3, 1'b1, 1'b0, 16'hE006, f1, l1, s1);
        send_pkt(2, 1'b0, 1'b1, 16'hE007, f2, l2, s2);
        drain();
        check("b2b_no_bubble", 256'(f2 - l1), 256'(1));
        check("b2b_A_beats", 256'(cnt_a - a0), 256'(3));
        check("b2b_D_beats", 256'(cnt_d - d0), 256'(2));

        // Reset during beat 2 of a 4-beat A packet
        s_axis_tuser = '0; s_axis_tuser[24] = 1'b1;
        s_axis_tdata = 64'h1111; s_axis_tstrb = 8'hFF; s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tdata = 64'h2222; s_axis_tuser = '0;
        @(posedge clk);
        #1;
        s_axis_tdata = 64'h3333;
        #1;
        arst_n = 1'b0;
        #1;
        check("mid_rst_A_tvalid", 256'(m_axis_A_tvalid), 256'(0));
        check("mid_rst_D_tvalid", 256'(m_axis_D_tvalid), 256'(0));
        check("mid_rst_s_tready", 256'(s_axis_tready), 256'(0));
        check("mid_rst_drop_cnt", 256'(drop_cnt), 256'(0));
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        #1;
        check("post_mid_rst_s_tready", 256'(s_axis_tready), 256'(1));
        @(posedge clk);
        #1;
        a0 = cnt_a; d0 = cnt_d; av0 = a_valid_cycles;
        send_pkt(2, 1'b0, 1'b1, 16'hF008, f1, l1, s1);
        drain();
        check("rst_next_D_beats", 256'(cnt_d - d0), 256'(2));
        check("rst_next_no_A", 256'(a_valid_cycles - av0), 256'(0));
        check("rst_final_drop_cnt", 256'(drop_cnt), 256'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
